// File: rtl/crc8_sched.sv
// crc8_sched: round-robin scheduler feeding one bit-serial CRC-8 engine
// (poly 0x131, init 0x00, MSB first, no reflection, no final XOR).
// A granted word is processed one bit per cycle, then held as a
// {word, crc} frame until downstream accepts it.
module crc8_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [39:0]          out_data,
  output logic [IDW-1:0]       out_id,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       word_q;
  logic [IDW-1:0]    id_q;
  logic [IDW-1:0]    last_grant_q;
  logic [7:0]        rem_q, rem_d;
  logic [4:0]        bit_cnt_q;
  logic [39:0]       out_data_q;
  logic [IDW-1:0]    out_id_q;
  logic [15:0]       frame_cnt_q;

  logic              grant_found;
  logic [IDW-1:0]    grant_id;
  logic [31:0]       grant_word;
  logic [NREQ-1:0]   grant_oh;
  logic              fb;

  // Round-robin pick: first valid requester after the last one granted.
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_id    = '0;
    grant_word  = '0;
    idx         = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_grant_q) + k) % NREQ;
      if (!grant_found && req_valid[idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[IDW-1:0];
        grant_word  = req_data[idx*32 +: 32];
      end
    end
    grant_oh = grant_found ? (NREQ'(1) << grant_id) : '0;
  end

  // One CRC step: ~bit_cnt_q walks the word from bit 31 down to bit 0.
  always_comb begin
    fb    = rem_q[7] ^ word_q[~bit_cnt_q];
    rem_d = {rem_q[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
  end

  // Next-state and grant strobe; req_ready is held off while reset is asserted.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          req_ready = rst_n ? grant_oh : '0;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        if (bit_cnt_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Word capture, CRC shifting and frame capture at the end of CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q       <= '0;
      id_q         <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      rem_q        <= '0;
      bit_cnt_q    <= '0;
      out_data_q   <= '0;
      out_id_q     <= '0;
    end else if (state_q == StIdle) begin
      if (grant_found) begin
        word_q       <= grant_word;
        id_q         <= grant_id;
        last_grant_q <= grant_id;
        rem_q        <= '0;
        bit_cnt_q    <= '0;
      end
    end else if (state_q == StCalc) begin
      rem_q     <= rem_d;
      bit_cnt_q <= bit_cnt_q + 5'd1;
      if (bit_cnt_q == 5'd31) begin
        out_data_q <= {word_q, rem_d};
        out_id_q   <= id_q;
      end
    end
  end

  // Delivered-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (state_q == StDone && out_ready) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_crc8_sched.sv
// Bench for crc8_sched: a cycle-level reference model (round-robin pick,
// cycles-since-grant timing, polynomial long division for the CRC) is
// compared against the DUT every cycle, plus hand-computed frame literals.
module tb_crc8_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [39:0]         out_data;
  logic [IDW-1:0]      out_id;
  logic                busy;
  logic [15:0]         frame_cnt;

  crc8_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference CRC: long division of {word, 8'h00} by 0x131.
  function automatic logic [7:0] crc_ref(input logic [31:0] w);
    logic [39:0] v;
    v = {w, 8'h00};
    for (int b = 39; b >= 8; b--) begin
      if (v[b]) v = v ^ (40'h131 << (b - 8));
    end
    return v[7:0];
  endfunction

  // Requesters: each presents words from its queue, one at a time.
  logic [31:0]     wq [NREQ][$];
  logic [NREQ-1:0] rv = '0;
  logic [31:0]     rd [NREQ] = '{default: 32'h0};
  logic [NREQ-1:0] acc = '0;

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = rd[i];
  end
  assign req_valid = rv;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) rv[i] = 1'b0;
      if (!rv[i] && wq[i].size() > 0) begin
        rd[i] = wq[i].pop_front();
        rv[i] = 1'b1;
      end
    end
  end

  // Model state and observation log.
  bit              m_active = 0;
  bit              m_loaded = 0;
  int              m_elapsed = 0;
  logic [IDW-1:0]  m_last = IDW'(NREQ - 1);
  logic [31:0]     m_word = '0;
  logic [7:0]      m_crc = '0;
  logic [IDW-1:0]  m_id = '0;
  logic [15:0]     m_frames = '0;

  int              gr_cyc = -1000;
  int              hs_cyc = -1000;
  int              ov_rise = -1000;
  bit              prev_ov = 0;
  logic [39:0]     last_frame = '0;
  logic [IDW-1:0]  last_fid = '0;
  int              frames_seen = 0;
  int              grants[$];

  always @(negedge clk) begin : monitor
    logic [NREQ-1:0] exp_rr;
    bit              found;
    bit              exp_ov;
    int              pick;
    int              idx;
    cyc++;
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_id", out_id, 0);
      m_active = 0; m_loaded = 0; m_elapsed = 0; m_frames = '0;
      m_last = IDW'(NREQ - 1);
      acc = '0; prev_ov = 0;
    end else begin
      found = 0; pick = 0; idx = 0;
      if (!m_active) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (int'(m_last) + k) % NREQ;
          if (!found && req_valid[idx]) begin found = 1; pick = idx; end
        end
      end
      exp_rr = found ? (NREQ'(1) << pick) : '0;
      exp_ov = m_active && (m_elapsed >= 33);
      check("req_ready", req_ready, exp_rr);
      check("busy", busy, m_active);
      check("out_valid", out_valid, exp_ov);
      check("frame_cnt", frame_cnt, m_frames);
      if (exp_ov) begin
        check("out_data", out_data, {m_word, m_crc});
        check("out_id", out_id, m_id);
      end else if (!m_loaded) begin
        check("out_data_reset", out_data, 0);
        check("out_id_reset", out_id, 0);
      end
      // Observation log from DUT outputs.
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) begin gr_cyc = cyc; grants.push_back(k); end
      if (out_valid && !prev_ov) ov_rise = cyc;
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        hs_cyc = cyc; last_frame = out_data; last_fid = out_id; frames_seen++;
      end
      acc = req_ready & req_valid;
      // Advance model by one cycle.
      if (exp_ov) m_loaded = 1;
      if (exp_ov && out_ready) begin
        m_active = 0;
        m_frames = m_frames + 16'd1;
      end else if (found) begin
        m_active = 1; m_elapsed = 1;
        m_word = req_data[32*pick +: 32];
        m_crc = crc_ref(m_word);
        m_id = pick[IDW-1:0];
        m_last = m_id;
      end else if (m_active) begin
        m_elapsed++;
      end
    end
  end

  function automatic bit queues_empty();
    for (int i = 0; i < NREQ; i++) if (wq[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(rv == '0 && queues_empty() && !busy && !out_valid) && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check("wait_idle_bound", n < budget, 1);
  endtask

  task automatic expect_frame(input int r, input logic [39:0] exp_frame,
                              input logic [15:0] exp_cnt);
    wait_idle(120);
    check("latency", ov_rise - gr_cyc, 33);
    check("frame", last_frame, exp_frame);
    check("frame_id", last_fid, r);
    check("frame_cnt_after", frame_cnt, exp_cnt);
  endtask

  task automatic run_single(input int r, input logic [31:0] w, input logic [39:0] exp_frame,
                            input logic [15:0] exp_cnt);
    sync();
    wq[r].push_back(w);
    expect_frame(r, exp_frame, exp_cnt);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n;
    int g0;
    int h;
    int fs;

    // Word presented during reset must not be granted until reset is released.
    wq[0].push_back(32'h0000_0001);
    repeat (4) @(negedge clk);
    #1;
    check("rst_literal_busy", busy, 0);
    check("rst_literal_req_ready", req_ready, 0);
    sync();
    rst_n = 1'b1;
    expect_frame(0, 40'h00_0000_0131, 16'd1);

    run_single(0, 32'h0000_0000, 40'h00_0000_0000, 16'd2);
    run_single(0, 32'h0000_0002, 40'h00_0000_0262, 16'd3);
    run_single(0, 32'h0000_0008, 40'h00_0000_08B9, 16'd4);
    run_single(3, 32'h0000_0003, 40'h00_0000_0353, 16'd5);

    // All requesters valid together; requester 0 has a second word queued.
    sync();
    grants.delete();
    wq[0].push_back(32'h1111_1111);
    wq[0].push_back(32'h5555_5555);
    wq[1].push_back(32'h2222_2222);
    wq[2].push_back(32'h3333_3333);
    wq[3].push_back(32'h4444_4444);
    wait_idle(400);
    check("rr_grant_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) check("rr_order", grants[i], exp_order[i]);
    check("rr_frame_cnt", frame_cnt, 16'd10);

    // Downstream stall for 10 cycles in DONE; requester 3 waits meanwhile.
    sync();
    out_ready = 1'b0;
    wq[2].push_back(32'h0000_0008);
    n = 0;
    while (!out_valid && n < 80) begin @(negedge clk); #1; n++; end
    check("stall_wait_bound", n < 80, 1);
    wq[3].push_back(32'h0000_0002);
    repeat (10) @(negedge clk);
    #1;
    check("stall_out_valid", out_valid, 1);
    check("stall_out_data", out_data, 40'h00_0000_08B9);
    check("stall_out_id", out_id, 2);
    check("stall_frame_cnt", frame_cnt, 16'd10);
    check("stall_no_grant", req_ready, 0);
    sync();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    h = hs_cyc;
    check("stall_frame_cnt_inc", frame_cnt, 16'd11);
    expect_frame(3, 40'h00_0000_0262, 16'd12);
    check("grant_after_handshake", gr_cyc - h, 1);

    // Reset in the middle of CALC discards the word; re-presented word completes.
    sync();
    g0 = gr_cyc;
    wq[1].push_back(32'h0000_0003);
    n = 0;
    while (gr_cyc == g0 && n < 20) begin @(negedge clk); #1; n++; end
    check("abort_grant_bound", n < 20, 1);
    repeat (17) @(posedge clk);
    #1;
    rst_n = 1'b0;
    fs = frames_seen;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_frame_cnt", frame_cnt, 0);
    check("abort_out_data", out_data, 0);
    rst_n = 1'b1;
    sync();
    wq[1].push_back(32'h0000_0003);
    expect_frame(1, 40'h00_0000_0353, 16'd1);
    check("abort_frames_seen", frames_seen - fs, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
